// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers: multi-cycle mult/multu/div/divu, single-cycle mthi/mtlo.
// Optional madd (MDUsel=111) is compiled in when MDU_MADD_EN is defined.
module mdu #(
    parameter int MUL_CYC = 5,
    parameter int DIV_CYC = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDUsel,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        MDU_RDsel,
    output logic        Busy,
    output logic [31:0] RD
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;
`ifdef MDU_MADD_EN
    localparam logic [2:0] OP_MADD  = 3'b111;
`endif

    localparam logic [3:0] MUL_LD = 4'(MUL_CYC);
    localparam logic [3:0] DIV_LD = 4'(DIV_CYC);

    typedef enum logic {IDLE, RUN} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic is_mul, is_div, is_multi;

    always_comb begin
        is_mul = (MDUsel == OP_MULT) || (MDUsel == OP_MULTU);
`ifdef MDU_MADD_EN
        is_mul = is_mul || (MDUsel == OP_MADD);
`endif
        is_div   = (MDUsel == OP_DIV) || (MDUsel == OP_DIVU);
        is_multi = is_mul || is_div;
    end

    // Result datapath works only on the latched operands, so forwarded inputs may change freely during RUN.
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign prod_u = {32'b0, a_q} * {32'b0, b_q};

    logic        div_sgn, neg_q, neg_r;
    logic [31:0] a_mag, b_mag, b_safe, qu, ru, quo, rem;

    // Signed division via magnitudes: quotient truncates to zero, remainder takes the dividend's sign.
    always_comb begin
        div_sgn = (op_q == OP_DIV);
        a_mag   = (div_sgn && a_q[31]) ? -a_q : a_q;
        b_mag   = (div_sgn && b_q[31]) ? -b_q : b_q;
        b_safe  = (b_q == 32'd0) ? 32'd1 : b_mag;
        qu      = a_mag / b_safe;
        ru      = a_mag % b_safe;
        neg_q   = div_sgn && (a_q[31] ^ b_q[31]);
        neg_r   = div_sgn && a_q[31];
        quo     = neg_q ? -qu : qu;
        rem     = neg_r ? -ru : ru;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    if (is_multi) begin
                        state_d = RUN;
                        cnt_d   = is_div ? DIV_LD : MUL_LD;
                        op_d    = MDUsel;
                        a_d     = A;
                        b_d     = B;
                    end else if (MDUsel == OP_MTHI) begin
                        hi_d = A;
                    end else if (MDUsel == OP_MTLO) begin
                        lo_d = A;
                    end
                end
            end
            RUN: begin
                cnt_d = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
                if (cnt_q <= 4'd1) begin
                    state_d = IDLE;
                    case (op_q)
                        OP_MULT:  {hi_d, lo_d} = prod_s;
                        OP_MULTU: {hi_d, lo_d} = prod_u;
                        OP_DIV, OP_DIVU: begin
                            if (b_q != 32'd0) begin
                                lo_d = quo;
                                hi_d = rem;
                            end
                        end
`ifdef MDU_MADD_EN
                        OP_MADD:  {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
`endif
                        default: ;
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 3'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign Busy = (state_q == RUN);
    assign RD   = MDU_RDsel ? hi_q : lo_q;

endmodule
